// File: rtl/tpu_result_drain_if.sv
// Stream bundle for the systolic-array result drain.
// Skewed column sums in; quantized rows and sticky status out.
interface tpu_result_drain_if #(
    parameter int K     = 2,
    parameter int ACC_W = 16,
    parameter int ROWS  = 2
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic [K-1:0]       col_valid;
    logic [K*ACC_W-1:0] col_data;
    logic               clr_err;
    logic               out_valid;
    logic               out_ready;
    logic [K*8-1:0]     out_data;
    logic [RW-1:0]      out_row_idx;
    logic               out_last;
    logic               overflow;
    logic               skew_err;
    logic               busy;

    modport master (
        output col_valid, col_data, clr_err, out_ready,
        input  out_valid, out_data, out_row_idx, out_last,
        input  overflow, skew_err, busy
    );

    modport slave (
        input  col_valid, col_data, clr_err, out_ready,
        output out_valid, out_data, out_row_idx, out_last,
        output overflow, skew_err, busy
    );
endinterface

// File: rtl/tpu_result_drain.sv
// Result drain: de-skews column sums, requantizes to int8,
// buffers rows in a FIFO and streams them with tile marking.
module tpu_result_drain #(
    parameter int K     = 2,
    parameter int ACC_W = 16,
    parameter int SHIFT = 4,
    parameter int DEPTH = 4,
    parameter int ROWS  = 2
) (
    input  logic               clk,
    input  logic               rst,
    tpu_result_drain_if.slave  bus
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int AW = $clog2(DEPTH);
    localparam logic [RW-1:0] LAST_IDX = RW'(ROWS - 1);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic signed [ACC_W-1:0] QMAX = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] QMIN = ACC_W'(-128);

    logic [K-1:0]     dv;
    logic [ACC_W-1:0] dd [K];
    logic [K-1:0]     stage_busy;

    // Column j waits K-1-j cycles so every lane of a row lines up.
    for (genvar j = 0; j < K; j++) begin : g_col
        localparam int L = K - 1 - j;
        if (L == 0) begin : g_pass
            assign dv[j] = bus.col_valid[j];
            assign dd[j] = bus.col_data[j*ACC_W +: ACC_W];
            assign stage_busy[j] = 1'b0;
        end else begin : g_dly
            logic [L-1:0]     vq;
            logic [ACC_W-1:0] dq [L];

            // Shift register for this column's valid and data.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    vq <= '0;
                    for (int s = 0; s < L; s++) begin
                        dq[s] <= '0;
                    end
                end else begin
                    vq[0] <= bus.col_valid[j];
                    dq[0] <= bus.col_data[j*ACC_W +: ACC_W];
                    for (int s = 1; s < L; s++) begin
                        vq[s] <= vq[s-1];
                        dq[s] <= dq[s-1];
                    end
                end
            end

            assign dv[j] = vq[L-1];
            assign dd[j] = dq[L-1];
            assign stage_busy[j] = |vq;
        end
    end

    logic aligned;
    logic mixed;

    assign aligned = &dv;
    assign mixed   = (|dv) && !aligned;

    logic [K*8-1:0] qrow;

    // Arithmetic shift then clamp each lane into int8 range.
    always_comb begin
        logic signed [ACC_W-1:0] sh;
        sh   = '0;
        qrow = '0;
        for (int j = 0; j < K; j++) begin
            sh = $signed(dd[j]) >>> SHIFT;
            if (sh > QMAX) begin
                qrow[j*8 +: 8] = 8'h7f;
            end else if (sh < QMIN) begin
                qrow[j*8 +: 8] = 8'h80;
            end else begin
                qrow[j*8 +: 8] = sh[7:0];
            end
        end
    end

    logic [K*8-1:0] mem [DEPTH];
    logic [AW-1:0]  wptr;
    logic [AW-1:0]  rptr;
    logic [AW:0]    count;
    logic           empty;
    logic           full;
    logic           pop;
    logic           push;
    logic           drop;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);
    assign pop   = !empty && bus.out_ready;
    assign push  = aligned && (!full || pop);
    assign drop  = aligned && full && !pop;

    // Row FIFO: a pop frees the slot a same-cycle push needs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= qrow;
                wptr      <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    logic [RW-1:0] ridx;

    // Position within the tile advances only on delivered rows.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ridx <= '0;
        end else if (pop) begin
            ridx <= (ridx == LAST_IDX) ? '0 : ridx + 1'b1;
        end
    end

    logic ovf_q;
    logic skew_q;

    // Sticky flags; a new event beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q  <= 1'b0;
            skew_q <= 1'b0;
        end else begin
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (bus.clr_err) begin
                ovf_q <= 1'b0;
            end
            if (mixed) begin
                skew_q <= 1'b1;
            end else if (bus.clr_err) begin
                skew_q <= 1'b0;
            end
        end
    end

    assign bus.out_valid   = !empty;
    assign bus.out_data    = empty ? '0 : mem[rptr];
    assign bus.out_row_idx = ridx;
    assign bus.out_last    = !empty && (ridx == LAST_IDX);
    assign bus.overflow    = ovf_q;
    assign bus.skew_err    = skew_q;
    assign bus.busy        = !empty || (|stage_busy);
endmodule

// File: tb/tb_tpu_result_drain.sv
// Bench for tpu_result_drain: directed scenarios plus random
// traffic checked every cycle against a queue-based model.
module tb_tpu_result_drain;
    localparam int K     = 2;
    localparam int ACC_W = 16;
    localparam int SHIFT = 4;
    localparam int DEPTH = 4;
    localparam int ROWS  = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    tpu_result_drain_if #(.K(K), .ACC_W(ACC_W), .ROWS(ROWS)) bus ();

    tpu_result_drain #(
        .K(K), .ACC_W(ACC_W), .SHIFT(SHIFT),
        .DEPTH(DEPTH), .ROWS(ROWS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_err    = 0;

    logic [K*8-1:0]     mq [$];
    int                 m_idx;
    bit                 m_ovf;
    bit                 m_skew;
    logic [K-1:0]       hv [K];
    logic [K*ACC_W-1:0] hd [K];

    logic [K*ACC_W-1:0] txq [$];

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] quant(logic [ACC_W-1:0] x);
        int v;
        v = int'($signed(x));
        v = v >>> SHIFT;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return 8'(v);
    endfunction

    // Model: a row completes when lane j's beat from j cycles
    // after lane 0 is present; history holds past inputs.
    always @(posedge clk or negedge rst) begin : model
        logic [K-1:0]   v;
        logic [K*8-1:0] row;
        bit             pop;
        bit             was_full;
        bit             set_o;
        bit             set_s;
        if (!rst) begin
            mq.delete();
            m_idx  = 0;
            m_ovf  = 0;
            m_skew = 0;
            for (int d = 0; d < K; d++) begin
                hv[d] = '0;
                hd[d] = '0;
            end
        end else begin
            v   = '0;
            row = '0;
            for (int j = 0; j < K; j++) begin
                int lag;
                lag = K - 1 - j;
                if (lag == 0) begin
                    v[j] = bus.col_valid[j];
                    row[j*8 +: 8] = quant(bus.col_data[j*ACC_W +: ACC_W]);
                end else begin
                    v[j] = hv[lag-1][j];
                    row[j*8 +: 8] = quant(hd[lag-1][j*ACC_W +: ACC_W]);
                end
            end
            was_full = (mq.size() == DEPTH);
            pop   = (mq.size() > 0) && bus.out_ready;
            set_o = 0;
            set_s = (v != '0) && !(&v);
            if (pop) begin
                void'(mq.pop_front());
                m_idx = (m_idx + 1) % ROWS;
            end
            if (&v) begin
                if (!was_full || pop) mq.push_back(row);
                else set_o = 1;
            end
            if (set_o) m_ovf = 1;
            else if (bus.clr_err) m_ovf = 0;
            if (set_s) m_skew = 1;
            else if (bus.clr_err) m_skew = 0;
            for (int d = K - 1; d > 0; d--) begin
                hv[d] = hv[d-1];
                hd[d] = hd[d-1];
            end
            hv[0] = bus.col_valid;
            hd[0] = bus.col_data;
        end
    end

    // Every cycle, compare all outputs against the model.
    always @(negedge clk) begin
        bit busy_m;
        busy_m = (mq.size() > 0);
        for (int j = 0; j < K - 1; j++) begin
            for (int d = 0; d < K - 1 - j; d++) begin
                if (hv[d][j]) busy_m = 1;
            end
        end
        check("out_valid", 32'(bus.out_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            check("out_data", 32'(bus.out_data), 32'(mq[0]));
            check("out_row_idx", 32'(bus.out_row_idx), 32'(m_idx));
            check("out_last", 32'(bus.out_last), 32'(m_idx == ROWS - 1));
        end else begin
            check("out_last_idle", 32'(bus.out_last), 32'd0);
        end
        check("overflow", 32'(bus.overflow), 32'(m_ovf));
        check("skew_err", 32'(bus.skew_err), 32'(m_skew));
        check("busy", 32'(bus.busy), 32'(busy_m));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.col_valid = '0;
        bus.col_data  = '0;
    endtask

    // Column j carries row (c - j) in cycle c.
    task automatic send_rows();
        int n;
        n = txq.size();
        for (int c = 0; c < n + K - 1; c++) begin
            for (int j = 0; j < K; j++) begin
                int r;
                r = c - j;
                if (r >= 0 && r < n) begin
                    bus.col_valid[j] = 1'b1;
                    bus.col_data[j*ACC_W +: ACC_W] = txq[r][j*ACC_W +: ACC_W];
                end else begin
                    bus.col_valid[j] = 1'b0;
                    bus.col_data[j*ACC_W +: ACC_W] = '0;
                end
            end
            tick();
        end
        idle();
        txq.delete();
    endtask

    task automatic load_ramp(int n);
        for (int v = 1; v <= n; v++) begin
            txq.push_back({16'(v * 16), 16'(v * 16)});
        end
    endtask

    logic               rs_v [K];
    logic [K*ACC_W-1:0] rs_d [K];

    initial begin
        idle();
        bus.clr_err   = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);

        // First row: lane0 then lane1 a cycle later.
        bus.out_ready = 1'b1;
        bus.col_valid = 2'b01;
        bus.col_data  = {16'h0000, 16'h0100};
        tick();
        bus.col_valid = 2'b10;
        bus.col_data  = {16'h0030, 16'h0000};
        tick();
        idle();
        check("t2_valid", 32'(bus.out_valid), 32'd1);
        check("t2_data", 32'(bus.out_data), 32'h0310);
        check("t2_model", 32'(mq[0]), 32'h0310);
        check("t2_idx", 32'(bus.out_row_idx), 32'd0);
        check("t2_last", 32'(bus.out_last), 32'd0);
        tick();

        // Saturation corners.
        bus.out_ready = 1'b0;
        txq.push_back({16'h8000, 16'h7fff});
        txq.push_back({16'h07f0, 16'hfff0});
        send_rows();
        check("sat_hi_lo", 32'(bus.out_data), 32'h807f);
        bus.out_ready = 1'b1;
        tick();
        check("sat_neg1_pos", 32'(bus.out_data), 32'h7fff);
        tick();
        bus.out_ready = 1'b0;

        // Reset mid-stream with two rows buffered.
        load_ramp(2);
        send_rows();
        check("pre_reset_busy", 32'(bus.busy), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", 32'(bus.out_data), 32'd0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        check("rst_skew", 32'(bus.skew_err), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        tick();
        rst = 1'b1;
        repeat (3) tick();
        check("post_rst_idle", 32'(bus.out_valid), 32'd0);

        // Backpressure: four buffered, fifth dropped.
        load_ramp(5);
        send_rows();
        check("bp_overflow", 32'(bus.overflow), 32'd1);
        check("bp_busy", 32'(bus.busy), 32'd1);
        check("bp_occupancy", 32'(mq.size()), 32'd4);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("bp_data", 32'(bus.out_data), 32'({8'(i + 1), 8'(i + 1)}));
            check("bp_idx", 32'(bus.out_row_idx), 32'(i % 2));
            check("bp_last", 32'(bus.out_last), 32'(i % 2));
            tick();
        end
        bus.out_ready = 1'b0;
        check("bp_drained", 32'(bus.out_valid), 32'd0);
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
        check("bp_clr", 32'(bus.overflow), 32'd0);

        // Full FIFO with a same-cycle pop and push.
        load_ramp(4);
        send_rows();
        bus.col_valid = 2'b01;
        bus.col_data  = {16'h0000, 16'h0050};
        tick();
        bus.col_valid = 2'b10;
        bus.col_data  = {16'h0050, 16'h0000};
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        idle();
        check("pp_occupancy", 32'(mq.size()), 32'd4);
        check("pp_overflow", 32'(bus.overflow), 32'd0);
        check("pp_head", 32'(bus.out_data), 32'h0202);
        bus.out_ready = 1'b1;
        repeat (5) tick();
        bus.out_ready = 1'b0;

        // Lane 1 arrives without its lane 0 partner.
        bus.col_valid = 2'b10;
        bus.col_data  = {16'h0123, 16'h0000};
        tick();
        idle();
        check("skew_set", 32'(bus.skew_err), 32'd1);
        check("skew_no_push", 32'(bus.out_valid), 32'd0);
        tick();
        check("skew_still_empty", 32'(bus.out_valid), 32'd0);
        bus.clr_err = 1'b1;
        tick();
        bus.clr_err = 1'b0;
        check("skew_clr", 32'(bus.skew_err), 32'd0);

        // Random traffic with occasional glitches and a reset.
        for (int d = 0; d < K; d++) begin
            rs_v[d] = 1'b0;
            rs_d[d] = '0;
        end
        for (int c = 0; c < 3000; c++) begin
            for (int d = K - 1; d > 0; d--) begin
                rs_v[d] = rs_v[d-1];
                rs_d[d] = rs_d[d-1];
            end
            rs_v[0] = ($urandom_range(0, 3) != 0);
            for (int j = 0; j < K; j++) begin
                if ($urandom_range(0, 1) == 1) begin
                    rs_d[0][j*ACC_W +: ACC_W] = ACC_W'($urandom);
                end else begin
                    rs_d[0][j*ACC_W +: ACC_W] = ACC_W'($signed(12'($urandom)));
                end
            end
            for (int j = 0; j < K; j++) begin
                bus.col_valid[j] = rs_v[j];
                bus.col_data[j*ACC_W +: ACC_W] = rs_d[j][j*ACC_W +: ACC_W];
            end
            if ($urandom_range(0, 63) == 0) begin
                bus.col_valid[$urandom_range(0, K - 1)] ^= 1'b1;
            end
            bus.out_ready = ($urandom_range(0, 9) < 6);
            bus.clr_err   = ($urandom_range(0, 49) == 0);
            if (c == 1500) begin
                rst = 1'b0;
                #2;
                rst = 1'b1;
                for (int d = 0; d < K; d++) rs_v[d] = 1'b0;
            end
            tick();
        end
        idle();
        bus.clr_err   = 1'b0;
        bus.out_ready = 1'b1;
        repeat (10) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
